enable_period_monitor: RTL and testbench

Consumer-side checker for periodic single-cycle enable strobes such as those produced by the team's clock-enable generators. It measures the clock-cycle interval between successive strobes and reports each measured period. It declares lock after a run of in-tolerance periods and flags out-of-window or missing strobes with a sticky error. It sits next to any strobe-driven datapath (UART baud tick, sample strobe) as a runtime health monitor.

---
 rtl/enable_period_monitor.sv | 134 +++++++++++++
 tb/tb_enable_period_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enable_period_monitor.sv
// Measures the cycle interval between single-cycle enable strobes, declares lock after
// LOCK_COUNT consecutive in-window periods, and raises a sticky error on a bad or missing strobe.
module enable_period_monitor #(
  parameter int EXPECTED_PERIOD = 51,
  parameter int TOLERANCE       = 1,
  parameter int LOCK_COUNT      = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr_err,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic [1:0]       o_dbg_state
);

  localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              in_window;
  logic              timeout;

  // o_period_valid is a one-cycle pulse with no backpressure: a consumer must capture
  // o_period in the cycle o_period_valid is high; o_period holds until the next pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    good_d    = good_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    err_set   = 1'b0;
    in_window = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    timeout   = (cnt_q == WIN_HI) && !i_en;

    if (i_en) begin
      cnt_d = CNT_W'(1);
    end else if ((state_q != S_IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          state_d = S_ACQUIRE;
          good_d  = '0;
        end
      end
      S_ACQUIRE: begin
        if (i_en) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          if (in_window) begin
            if (good_q == GOOD_LAST) begin
              state_d = S_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (i_en) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          if (!in_window) begin
            err_set = 1'b1;
            state_d = S_ACQUIRE;
            good_d  = '0;
          end
        end else if (timeout) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh error beats a simultaneous clear request.
    err_d    = err_set | (err_q & ~i_clr_err);
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign o_period       = period_q;
  assign o_period_valid = valid_q;
  assign o_locked       = locked_q;
  assign o_err          = err_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_enable_period_monitor.sv
// Directed bench for enable_period_monitor: timestamp-based reference model checked every
// cycle, a queue of expected periods, and literal expectations at key points.
module tb_enable_period_monitor;

  localparam int EP  = 51;
  localparam int TOL = 1;
  localparam int LC  = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_en = 1'b0;
  logic         i_clr_err = 1'b0;
  logic [W-1:0] o_period;
  logic         o_period_valid;
  logic         o_locked;
  logic         o_err;
  logic [1:0]   o_dbg_state;

  enable_period_monitor #(
    .EXPECTED_PERIOD(EP),
    .TOLERANCE      (TOL),
    .LOCK_COUNT     (LC),
    .CNT_W          (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_clr_err     (i_clr_err),
    .o_period      (o_period),
    .o_period_valid(o_period_valid),
    .o_locked      (o_locked),
    .o_err         (o_err),
    .o_dbg_state   (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // reference model: strobe timestamps rather than a running counter
  longint       m_cycle = 0;
  longint       m_last = 0;
  bit           m_meas = 0;
  bit           m_lock = 0;
  int           m_run = 0;
  logic [W-1:0] m_period = '0;
  bit           m_valid = 0;
  bit           m_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cycle = 0; m_last = 0; m_meas = 0; m_lock = 0; m_run = 0;
    m_period = '0; m_valid = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit en, input bit clr);
    longint p;
    bit     set_err;
    bit     in_win;
    set_err = 0;
    m_valid = 0;
    if (en) begin
      if (m_meas) begin
        p = m_cycle - m_last;
        if (p > (2**W - 1)) p = 2**W - 1;
        in_win   = (p >= EP - TOL) && (p <= EP + TOL);
        m_period = W'(p);
        m_valid  = 1;
        exp_q.push_back(W'(p));
        if (m_lock) begin
          if (!in_win) begin
            set_err = 1; m_lock = 0; m_run = 0;
          end
        end else if (in_win) begin
          m_run++;
          if (m_run == LC) begin
            m_lock = 1; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        m_meas = 1; m_run = 0;
      end
      m_last = m_cycle;
    end else if (m_meas && (m_cycle - m_last == EP + TOL)) begin
      if (m_lock) set_err = 1;
      m_meas = 0;
      m_lock = 0;
    end
    m_err = set_err ? 1'b1 : (clr ? 1'b0 : m_err);
    m_cycle++;
  endtask

  // scoreboard: model advances on each edge, DUT compared just after it
  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step(i_en, i_clr_err);
    #1;
    check("valid", o_period_valid, m_valid);
    check("locked", o_locked, m_lock);
    check("err", o_err, m_err);
    check("period", o_period, m_period);
    if (o_period_valid) begin
      check("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) check("sb_period", o_period, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic drive(input logic en, input logic clr);
    @(negedge clk);
    i_en = en;
    i_clr_err = clr;
  endtask

  task automatic strobe_after(input int k);
    repeat (k - 1) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_period", o_period, 0);
    check("rst_valid", o_period_valid, 0);
    check("rst_locked", o_locked, 0);
    check("rst_err", o_err, 0);
    rst = 1'b0;

    // acquire and lock on nominal spacing
    drive(1'b1, 1'b0); settle;
    check("first_valid", o_period_valid, 0);
    for (int i = 0; i < 4; i++) begin
      strobe_after(51); settle;
      check("lock_valid", o_period_valid, 1);
      check("lock_period", o_period, 51);
      check("lock_state", o_locked, (i == 3) ? 1 : 0);
    end
    check("lock_err", o_err, 0);

    // early strobe while locked, relock on 50, then clear
    strobe_after(49); settle;
    check("bad_period", o_period, 49);
    check("bad_err", o_err, 1);
    check("bad_unlock", o_locked, 0);
    repeat (4) strobe_after(50);
    settle;
    check("relock", o_locked, 1);
    check("relock_err", o_err, 1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    check("clr_err", o_err, 0);

    // missing strobe while locked
    repeat (60) drive(1'b0, 1'b0);
    check("miss_err", o_err, 1);
    check("miss_unlock", o_locked, 0);
    drive(1'b1, 1'b0); settle;
    check("restart_valid", o_period_valid, 0);
    repeat (4) strobe_after(51);
    settle;
    check("relock2", o_locked, 1);

    // burst of consecutive strobes while locked
    drive(1'b0, 1'b1);
    strobe_after(50);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    settle;
    check("burst_period", o_period, 1);
    check("burst_err", o_err, 1);
    check("burst_unlock", o_locked, 0);
    repeat (6) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check("burst_nolock", o_locked, 0);
    check("burst_period2", o_period, 1);

    // clear collisions
    drive(1'b0, 1'b1);
    strobe_after(50);
    repeat (3) strobe_after(51);
    settle;
    check("relock3", o_locked, 1);
    check("relock3_err", o_err, 0);
    strobe_after(49); settle;
    check("bad2_err", o_err, 1);
    repeat (48) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1); settle;
    check("acq_clr_err", o_err, 0);
    check("acq_bad_period", o_period, 49);
    repeat (4) strobe_after(51);
    settle;
    check("relock4", o_locked, 1);
    repeat (51) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1); settle;
    check("set_wins_err", o_err, 1);
    check("set_wins_unlock", o_locked, 0);

    // asynchronous reset mid-cycle, then restart from idle
    drive(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_period", o_period, 0);
    check("arst_valid", o_period_valid, 0);
    check("arst_locked", o_locked, 0);
    check("arst_err", o_err, 0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0); settle;
    check("post_rst_valid", o_period_valid, 0);
    strobe_after(51); settle;
    check("post_rst_valid2", o_period_valid, 1);
    check("post_rst_period", o_period, 51);

    drive(1'b0, 1'b0);
    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
